// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and helpers for the scoreboarded decode-stage register file.
package regfile_scoreboard_pkg;
  localparam int REG_ZERO = 0;
  localparam int REG_A5   = 15;
  localparam int REG_A7   = 17;

  localparam logic [31:0] STALL_SAT = 32'hFFFF_FFFF;

  // LSB position of lane 'lane' inside a packed multi-port bus.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction
endpackage

// File: rtl/regfile_scoreboard_bits.sv
// Per-register busy flags: flush beats everything, a set beats a same-cycle clear.
module regfile_scoreboard_bits
  import regfile_scoreboard_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         set_en_i,
  input  logic [ADDR_WIDTH-1:0]        set_addr_i,
  input  logic                         clr_en_i,
  input  logic [ADDR_WIDTH-1:0]        clr_addr_i,
  input  logic                         flush_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] look_addr_i,
  output logic [NUM_RD-1:0]            busy_o
);
  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
      if (set_en_i) busy_d[set_addr_i] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_look
    assign busy_o[i] = busy_q[look_addr_i[lane_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH]];
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with NUM_RD read ports, writeback bypass and a
// busy scoreboard that stalls issue on read-after-write hazards.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_RD     = 2,
  parameter int                    ECALL_REG  = REG_A5,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] in_raddr,
  input  logic [ADDR_WIDTH-1:0]        in_rd,
  input  logic                         in_rd_wen,
  input  logic                         in_ecall,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_RD*DATA_WIDTH-1:0] out_rdata,
  input  logic                         wb_valid,
  input  logic                         wb_wen,
  input  logic [ADDR_WIDTH-1:0]        wb_addr,
  input  logic [DATA_WIDTH-1:0]        wb_data,
  input  logic                         flush,
  output logic [31:0]                  stall_cnt
);
  localparam int                    NREG      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ECALL_IDX = ADDR_WIDTH'(ECALL_REG);

  logic [DATA_WIDTH-1:0]        rf_q [NREG];
  logic [NUM_RD*ADDR_WIDTH-1:0] eff;
  logic [NUM_RD-1:0]            busy_hit, hz;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic                         out_valid_q, out_valid_d;
  logic [31:0]                  stall_cnt_q, stall_cnt_d;
  logic                         accept;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    logic [ADDR_WIDTH-1:0] idx;
    logic                  wb_hit;
    if (i == 1) begin : g_ecall
      assign idx = in_ecall ? ECALL_IDX : in_raddr[lane_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
    end else begin : g_plain
      assign idx = in_raddr[lane_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
    end
    assign eff[lane_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH] = idx;
    assign wb_hit = wb_valid && (wb_addr == idx);
    // A writeback landing this cycle resolves the hazard; its data is bypassed below.
    assign hz[i]  = busy_hit[i] && !wb_hit;
    assign rdata_d[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] =
        (idx == '0)          ? '0      :
        (wb_hit && wb_wen)   ? wb_data : rf_q[idx];
  end

  regfile_scoreboard_bits #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_RD     (NUM_RD)
  ) u_bits (
    .clk         (clk),
    .reset       (reset),
    .set_en_i    (accept && in_rd_wen && (in_rd != '0)),
    .set_addr_i  (in_rd),
    .clr_en_i    (wb_valid),
    .clr_addr_i  (wb_addr),
    .flush_i     (flush),
    .look_addr_i (eff),
    .busy_o      (busy_hit)
  );

  assign in_ready = (!out_valid_q || out_ready) && !flush && !(|hz);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (accept)    out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;

    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && (stall_cnt_q != STALL_SAT))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      rdata_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      stall_cnt_q <= stall_cnt_d;
      if (accept) rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) rf_q[r] <= RESET_VAL;
    end else if (wb_valid && wb_wen && (wb_addr != '0)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_rdata = rdata_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, bypass, hazards, hold, ecall, flush.
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_rd_wen, in_ecall;
  logic [9:0]  in_raddr;
  logic [4:0]  in_rd, wb_addr;
  logic        out_valid, out_ready;
  logic [63:0] out_rdata;
  logic        wb_valid, wb_wen, flush;
  logic [31:0] wb_data, stall_cnt;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_raddr  (in_raddr),
    .in_rd     (in_rd),
    .in_rd_wen (in_rd_wen),
    .in_ecall  (in_ecall),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rdata (out_rdata),
    .wb_valid  (wb_valid),
    .wb_wen    (wb_wen),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_valid = 1'b1; wb_wen = 1'b1; wb_addr = a; wb_data = d;
  endtask

  task automatic wb_off();
    wb_valid = 1'b0; wb_wen = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; in_raddr = '0; in_rd = '0; in_rd_wen = 0; in_ecall = 0;
    out_ready = 1'b1; flush = 0;
    wb_off();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_rdata", out_rdata, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    reset = 1'b0;
    #1 check("rst_in_ready", in_ready, 1);

    // Basic read of reset registers x1/x2
    in_valid = 1; in_raddr = {5'd2, 5'd1};
    #1 check("basic_in_ready", in_ready, 1);
    tick();
    in_valid = 0;
    check("basic_out_valid", out_valid, 1);
    check("basic_rdata", out_rdata, 64'h0);
    check("basic_stall", stall_cnt, 0);
    tick();
    check("consume_out_valid", out_valid, 0);

    // Writeback then read x5; x0 write ignored
    wb(5'd5, 32'hDEAD_BEEF);
    tick();
    wb_off();
    in_valid = 1; in_raddr = {5'd0, 5'd5};
    tick();
    in_valid = 0;
    check("rd_x5", out_rdata, {32'h0, 32'hDEAD_BEEF});
    wb(5'd0, 32'h1234);
    tick();
    wb_off();
    in_valid = 1; in_raddr = {5'd0, 5'd0};
    tick();
    in_valid = 0;
    check("rd_x0", out_rdata, 64'h0);

    // RAW hazard on x7, resolved by same-cycle writeback bypass
    in_valid = 1; in_raddr = '0; in_rd = 5'd7; in_rd_wen = 1;
    tick();
    in_rd_wen = 0; in_rd = '0; in_raddr = {5'd0, 5'd7};
    #1 check("raw_in_ready", in_ready, 0);
    repeat (3) tick();
    check("raw_stall_3", stall_cnt, 3);
    check("raw_still_stalled", in_ready, 0);
    wb(5'd7, 32'h55);
    #1 check("raw_wb_ready", in_ready, 1);
    tick();
    wb_off(); in_valid = 0;
    check("raw_out_valid", out_valid, 1);
    check("raw_bypass", out_rdata, {32'h0, 32'h55});
    check("raw_stall_after", stall_cnt, 3);
    in_raddr = {5'd0, 5'd7};
    #1 check("x7_not_busy", in_ready, 1);

    // Backpressure hold for 4 cycles, then consume + accept on one edge
    out_ready = 0; in_valid = 1; in_raddr = {5'd0, 5'd5};
    #1 check("hold_in_ready", in_ready, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("hold_rdata", out_rdata, {32'h0, 32'h55});
      check("hold_valid", out_valid, 1);
    end
    check("hold_stall", stall_cnt, 7);
    out_ready = 1;
    #1 check("b2b_in_ready", in_ready, 1);
    tick();
    in_valid = 0;
    check("b2b_out_valid", out_valid, 1);
    check("b2b_rdata", out_rdata, {32'h0, 32'hDEAD_BEEF});
    check("b2b_stall", stall_cnt, 7);
    tick();

    // ecall forces port 1 to x15
    wb(5'd15, 32'hA5);
    tick();
    wb_off();
    in_valid = 1; in_ecall = 1; in_raddr = {5'd3, 5'd5};
    tick();
    check("ecall_rdata", out_rdata, {32'hA5, 32'hDEAD_BEEF});
    in_ecall = 0; in_raddr = '0; in_rd = 5'd15; in_rd_wen = 1;
    tick();
    in_rd_wen = 0; in_rd = '0; in_ecall = 1; in_raddr = {5'd3, 5'd0};
    #1 check("ecall_busy_ready", in_ready, 0);
    tick();
    check("ecall_stall", stall_cnt, 8);
    wb(5'd15, 32'h77);
    #1 check("ecall_wb_ready", in_ready, 1);
    tick();
    wb_off(); in_valid = 0; in_ecall = 0;
    check("ecall_bypass", out_rdata, {32'h77, 32'h0});

    // Flush clears busy x9; a same-cycle writeback still lands
    in_valid = 1; in_raddr = '0; in_rd = 5'd9; in_rd_wen = 1;
    tick();
    in_valid = 0; in_rd_wen = 0; in_rd = '0; flush = 1;
    wb(5'd10, 32'hAB);
    #1 check("flush_in_ready", in_ready, 0);
    tick();
    flush = 0; wb_off();
    check("flush_out_valid", out_valid, 0);
    in_valid = 1; in_raddr = {5'd10, 5'd9};
    #1 check("flush_busy_clr", in_ready, 1);
    tick();
    in_valid = 0; out_ready = 0;
    check("flush_read", out_rdata, {32'hAB, 32'h0});
    tick();
    check("prehold_valid", out_valid, 1);

    // Mid-hold reset drops state asynchronously
    #2 reset = 1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_rdata", out_rdata, 0);
    check("async_rst_stall", stall_cnt, 0);
    tick();
    reset = 0; out_ready = 1;
    in_valid = 1; in_raddr = {5'd15, 5'd5};
    tick();
    in_valid = 0;
    check("rst_rf_cleared", out_rdata, 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
